// File: rtl/out_reg_scheduler_if.sv
// ---------------------------------------------------------------------------
// out_reg_scheduler_if
//   Bundles the writer handshakes, the flush control and the reg_out drive
//   signals of out_reg_scheduler.
//   master : the environment (CPU OUT path, debug port, flush source)
//   slave  : the scheduler itself
// Signals
//   flush                 sync: empty the FIFO, abort the current hold
//   cpu_req/cpu_data      CPU write request and value; cpu_ack pulses on push
//   dbg_req/dbg_data      debug write request and value; dbg_ack pulses on push
//   out_load/out_bus      load strobe and registered data towards reg_out
//   busy                  scheduler FSM is not idle
//   fifo_full/fifo_empty  FIFO occupancy flags
//   count                 entries resident in the FIFO
// ---------------------------------------------------------------------------
interface out_reg_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             cpu_req;
    logic [WIDTH-1:0] cpu_data;
    logic             cpu_ack;
    logic             dbg_req;
    logic [WIDTH-1:0] dbg_data;
    logic             dbg_ack;
    logic             out_load;
    logic [WIDTH-1:0] out_bus;
    logic             busy;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    count;

    modport master (
        output flush, cpu_req, cpu_data, dbg_req, dbg_data,
        input  cpu_ack, dbg_ack, out_load, out_bus, busy,
               fifo_full, fifo_empty, count
    );

    modport slave (
        input  flush, cpu_req, cpu_data, dbg_req, dbg_data,
        output cpu_ack, dbg_ack, out_load, out_bus, busy,
               fifo_full, fifo_empty, count
    );
endinterface

// File: rtl/out_reg_scheduler.sv
// ---------------------------------------------------------------------------
// out_reg_scheduler
//   Shares the SAP-1 output register between the CPU OUT path and a debug
//   port. Accepted values are queued in a small circular FIFO; each one is
//   presented to reg_out with a single-cycle load strobe and then held for
//   HOLD_CYCLES cycles before the next value may be loaded.
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   sif   out_reg_scheduler_if.slave: writer handshakes, flush, reg_out drive,
//         status (busy, fifo_full, fifo_empty, count)
// ---------------------------------------------------------------------------
module out_reg_scheduler #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    out_reg_scheduler_if.slave sif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [TW-1:0]    r_timer;
    logic             r_rr_last_dbg;   // 1: debug won the last contention
    logic [WIDTH-1:0] r_out_bus;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_both;
    logic             w_grant_cpu;
    logic             w_grant_dbg;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_wdata;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Arbitration: a push only ever uses the current full flag, so a pop in
    // the same cycle does not open a slot for a push-through.
    assign w_push_ok   = !w_full && !sif.flush;
    assign w_both      = sif.cpu_req && sif.dbg_req;
    assign w_grant_cpu = w_push_ok && sif.cpu_req && (!sif.dbg_req || r_rr_last_dbg);
    assign w_grant_dbg = w_push_ok && sif.dbg_req && (!sif.cpu_req || !r_rr_last_dbg);
    assign w_push      = w_grant_cpu || w_grant_dbg;
    assign w_wdata     = w_grant_dbg ? sif.dbg_data : sif.cpu_data;

    // The head is popped on the IDLE->LOAD edge and captured into out_bus.
    assign w_pop = (r_state == S_IDLE) && !w_empty && !sif.flush;

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (!w_empty)      w_next_state = S_LOAD;
            S_LOAD:                    w_next_state = S_HOLD;
            S_HOLD: if (r_timer == '0) w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
        if (sif.flush) w_next_state = S_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    // out_load is decoded from the registered state, so it is a clean
    // one-cycle strobe aligned with the freshly registered out_bus.
    always_comb begin
        sif.out_load   = (r_state == S_LOAD);
        sif.busy       = (r_state != S_IDLE);
        sif.out_bus    = r_out_bus;
        sif.cpu_ack    = w_grant_cpu;
        sif.dbg_ack    = w_grant_dbg;
        sif.fifo_full  = w_full;
        sif.fifo_empty = w_empty;
        sif.count      = r_count;
    end

    // Hold timer: loaded on LOAD->HOLD, counts down to zero inside HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                r_timer <= '0;
        else if (sif.flush)                      r_timer <= '0;
        else if (r_state == S_LOAD)              r_timer <= TW'(HOLD_CYCLES - 1);
        else if (r_state == S_HOLD && r_timer != '0) r_timer <= r_timer - 1'b1;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (sif.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers gate every read,
    // so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wdata;
    end

    // Round-robin memory only moves when both writers actually contended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 r_rr_last_dbg <= 1'b1;
        else if (w_push && w_both) r_rr_last_dbg <= w_grant_dbg;
    end

    // out_bus only changes on a pop (IDLE->LOAD) or reset; flush keeps it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_out_bus <= '0;
        else if (w_pop) r_out_bus <= r_mem[r_rd_ptr];
    end
endmodule

// File: tb/tb_out_reg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_out_reg_scheduler
//   Directed self-checking bench for out_reg_scheduler (WIDTH=8, DEPTH=4,
//   HOLD_CYCLES=16). Inputs change 1ns after the rising edge; outputs are
//   sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_out_reg_scheduler;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    // Observed load history
    logic [WIDTH-1:0] load_q[$];
    int               load_cyc_q[$];
    int               busy_cnt;
    int               max_count;
    int               full_cyc;

    out_reg_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) sif ();

    out_reg_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (sif.out_load) begin
                load_q.push_back(sif.out_bus);
                load_cyc_q.push_back(cyc);
            end
            if (sif.busy) busy_cnt++;
            if (int'(sif.count) > max_count) max_count = int'(sif.count);
            if (sif.fifo_full && full_cyc < 0) full_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_at(input int i);
        if (i < load_q.size()) return 32'(load_q[i]);
        return 32'hDEAD;
    endfunction

    function automatic int load_cyc_at(input int i);
        if (i < load_cyc_q.size()) return load_cyc_q[i];
        return -1000;
    endfunction

    task automatic do_reset();
        rst          = 1'b0;
        sif.flush    = 1'b0;
        sif.cpu_req  = 1'b0;
        sif.cpu_data = '0;
        sif.dbg_req  = 1'b0;
        sif.dbg_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_q.delete();
        load_cyc_q.delete();
        busy_cnt  = 0;
        max_count = 0;
        full_cyc  = -1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One write through a single requester; returns the ack cycle.
    task automatic do_write(input bit is_dbg, input logic [WIDTH-1:0] d, output int ack_cyc);
        bit seen;
        seen    = 1'b0;
        ack_cyc = -1;
        if (is_dbg) begin sif.dbg_req = 1'b1; sif.dbg_data = d; end
        else        begin sif.cpu_req = 1'b1; sif.cpu_data = d; end
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (is_dbg ? sif.dbg_ack : sif.cpu_ack) begin
                seen    = 1'b1;
                ack_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (is_dbg) sif.dbg_req = 1'b0;
        else        sif.cpu_req = 1'b0;
        check(is_dbg ? "dbg_ack_seen" : "cpu_ack_seen", 32'(seen), 32'd1);
    endtask

    // Both writers request together; each drops its req after its own ack.
    task automatic both_write(input logic [WIDTH-1:0] cd, input logic [WIDTH-1:0] dd,
                              output int c_cyc, output int d_cyc);
        c_cyc = -1;
        d_cyc = -1;
        sif.cpu_req = 1'b1; sif.cpu_data = cd;
        sif.dbg_req = 1'b1; sif.dbg_data = dd;
        for (int i = 0; i < 100 && (c_cyc < 0 || d_cyc < 0); i++) begin
            @(negedge clk);
            if (sif.cpu_ack) c_cyc = cyc;
            if (sif.dbg_ack) d_cyc = cyc;
            @(posedge clk);
            #1;
            if (c_cyc >= 0) sif.cpu_req = 1'b0;
            if (d_cyc >= 0) sif.dbg_req = 1'b0;
        end
        sif.cpu_req = 1'b0;
        sif.dbg_req = 1'b0;
        check("both_acks_seen", 32'(c_cyc >= 0 && d_cyc >= 0), 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!sif.busy && sif.fifo_empty) done = 1'b1;
        end
        check("idle_reached", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, a, b, c2, d2, fc;
        int acks[6];
        logic [WIDTH-1:0] vals[6];

        // ---- Reset values while held in reset ----
        rst = 1'b0;
        sif.flush = 1'b0; sif.cpu_req = 1'b0; sif.dbg_req = 1'b0;
        sif.cpu_data = '0; sif.dbg_data = '0;
        #12;
        check("rst_out_load", 32'(sif.out_load), 32'd0);
        check("rst_out_bus",  32'(sif.out_bus),  32'h00);
        check("rst_busy",     32'(sif.busy),     32'd0);
        check("rst_count",    32'(sif.count),    32'd0);
        check("rst_empty",    32'(sif.fifo_empty), 32'd1);

        // ---- 1. Asynchronous reset mid-HOLD with 3 entries queued ----
        do_reset();
        do_write(1'b0, 8'hA1, a);
        do_write(1'b0, 8'hA2, a);
        do_write(1'b0, 8'hA3, a);
        do_write(1'b0, 8'hA4, a);
        @(negedge clk);
        check("t1_pre_count", 32'(sif.count), 32'd3);
        check("t1_pre_busy",  32'(sif.busy),  32'd1);
        check("t1_pre_bus",   32'(sif.out_bus), 32'hA1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t1_async_out_load", 32'(sif.out_load), 32'd0);
        check("t1_async_out_bus",  32'(sif.out_bus),  32'h00);
        check("t1_async_count",    32'(sif.count),    32'd0);
        check("t1_async_busy",     32'(sif.busy),     32'd0);

        // ---- 2. Single write latency and busy length ----
        do_reset();
        do_write(1'b0, 8'h2A, n);
        wait_idle();
        check("t2_nloads",    32'(load_q.size()), 32'd1);
        check("t2_load_cyc",  32'(load_cyc_at(0)), 32'(n + 2));
        check("t2_load_data", load_at(0), 32'h2A);
        check("t2_busy_len",  32'(busy_cnt), 32'(HOLD + 1));

        // ---- 3. Contention and round-robin ----
        do_reset();
        both_write(8'h0F, 8'hAA, a, b);
        check("t3_dbg_after_cpu", 32'(b), 32'(a + 1));
        wait_idle();
        check("t3_load0", load_at(0), 32'h0F);
        check("t3_load1", load_at(1), 32'hAA);
        check("t3_spacing", 32'(load_cyc_at(1) - load_cyc_at(0)), 32'(HOLD + 2));
        both_write(8'h55, 8'h66, c2, d2);
        check("t3_rr_cpu_after_dbg", 32'(c2), 32'(d2 + 1));
        wait_idle();
        check("t3_load2", load_at(2), 32'h66);
        check("t3_load3", load_at(3), 32'h55);

        // ---- 4. Full FIFO stalls the CPU ----
        do_reset();
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) do_write(1'b0, vals[i], acks[i]);
        fc = full_cyc;
        check("t4_ack55", 32'(acks[4]), 32'(acks[0] + 4));
        check("t4_full_rise", 32'(fc), 32'(acks[0] + 5));
        check("t4_ack66", 32'(acks[5]), 32'(acks[0] + HOLD + 4));
        wait_idle();
        check("t4_nloads", 32'(load_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t4_load%0d", i), load_at(i), 32'(vals[i]));

        // ---- 5. Flush during HOLD ----
        do_reset();
        do_write(1'b0, 8'h3C, a);
        do_write(1'b0, 8'h4D, a);
        do_write(1'b0, 8'h5E, a);
        @(negedge clk);
        check("t5_pre_count", 32'(sif.count), 32'd2);
        check("t5_pre_busy",  32'(sif.busy),  32'd1);
        @(posedge clk);
        #1 sif.flush = 1'b1;
        @(posedge clk);
        #1 sif.flush = 1'b0;
        @(negedge clk);
        check("t5_count", 32'(sif.count), 32'd0);
        check("t5_busy",  32'(sif.busy),  32'd0);
        check("t5_empty", 32'(sif.fifo_empty), 32'd1);
        check("t5_bus",   32'(sif.out_bus), 32'h3C);
        repeat (40) @(negedge clk);
        check("t5_no_more_loads", 32'(load_q.size()), 32'd1);
        check("t5_bus_kept", 32'(sif.out_bus), 32'h3C);

        // ---- 6. Wrap: debug streams ten values ----
        do_reset();
        for (int i = 1; i <= 10; i++) do_write(1'b1, 8'(i), a);
        wait_idle();
        check("t6_nloads", 32'(load_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) check($sformatf("t6_load%0d", i), load_at(i), 32'(i + 1));
        check("t6_max_count", 32'(max_count), 32'd4);
        check("t6_final_count", 32'(sif.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
